id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port instr_in, input, 32, instruction held in the IF/ID register.
REQ-004 SHALL have port flush, input, 1, taken branch resolved in EX; kills the instruction in ID.
REQ-005 SHALL have ports wb_en (1), wb_addr (5) and wb_data (64), all inputs, forming the writeback port.
REQ-006 SHALL have ports ex_rd (5), ex_regwrite (1), ex_memtoreg (1) and ex_result (64), all inputs, describing the instruction now in EX.
REQ-007 SHALL have ports mem_rd (5), mem_regwrite (1) and mem_result (64), all inputs, describing the instruction now in MEM.
REQ-008 SHALL have ports Da, Db, output, 64 each, registered operands to EX.
REQ-009 SHALL have port instr, output, 32, registered instruction to EX.
REQ-010 SHALL have port controlsigs, output, 14, registered; bit 13..0 = Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, BrTaken, UncondBr, ALUOp2, ALUOp1, ALUOp0, BigImm, Shift, SetFlag, isLTnotCBZ.
REQ-011 SHALL have port rd_out, output, 5, registered destination = instr_in[4:0].
REQ-012 SHALL have port stall, output, 1, combinational; holds PC and IF/ID when high.

Function
REQ-013 SHALL decode instr_in to controlsigs as follows; all other encodings decode to BUBBLE.
- ADDI (instr_in[31:22]=1001000100) = 0x3428.
- ADDS (instr_in[31:21]=10101011000) = 0x2422.
- SUBS (instr_in[31:21]=11101011000) = 0x2432.
- LDUR (instr_in[31:21]=11111000010) = 0x3C20.
- STUR (instr_in[31:21]=11111000000) = 0x1220.
- LSR (instr_in[31:21]=11010011010) = 0x2404.
- B (instr_in[31:26]=000101) = 0x0180.
- B.LT (instr_in[31:24]=01010100 with instr_in[4:0]=01011) = 0x0001.
- CBZ (instr_in[31:24]=10110100) = 0x0000.
- BUBBLE = 0x0080.
REQ-014 SHALL read Ra = instr_in[9:5], and Rb = instr_in[20:16] when Reg2Loc=1, else instr_in[4:0].
REQ-015 SHALL treat Ra as used for ADDI, ADDS, SUBS, LDUR, STUR and LSR, and Rb as used for ADDS, SUBS, STUR and CBZ.
REQ-016 SHALL select each operand by priority:
- register 31 reads as 0;
- else ex_result if ex_regwrite, ex_rd matches and ex_rd != 31;
- else mem_result if mem_regwrite, mem_rd matches and mem_rd != 31;
- else wb_data if wb_en, wb_addr matches and wb_addr != 31;
- else the regfile contents.
REQ-017 SHALL drive stall=1 when ex_memtoreg=1, ex_regwrite=1, ex_rd != 31 and ex_rd equals a used source of instr_in.
REQ-018 SHALL load the ID/EX registers on every clock edge; latency is 1 cycle from instr_in to outputs.
REQ-019 SHALL load BUBBLE (controlsigs=0x0080, instr=0, rd_out=31, Da=Db=0) when stall=1 or flush=1; flush takes priority and forces stall=0.
REQ-020 SHALL write wb_data to register wb_addr on the rising edge when wb_en=1 and wb_addr != 31; writes to register 31 are ignored.

Reset
REQ-021 SHALL, while reset=1, force:
- ID/EX outputs to BUBBLE values (Da=0, Db=0, instr=0, controlsigs=0x0080, rd_out=31);
- stall=0;
- all regfile entries to 0.
REQ-022 SHALL, on reset asserted mid-operation, discard the in-flight instruction and any same-edge regfile write.

Structure
REQ-023 SHALL place the controlsig bit positions, opcode constants, CTRL_* values and BUBBLE in shared package cpu_pkg.
REQ-024 SHALL instantiate one sub-module, regfile_32x64, with 2 asynchronous read ports and 1 synchronous write port; bypassing stays in id_stage.

Verification
REQ-025 SHALL cover: reset held, then ADDI X1,X31,#5 -> next edge controlsigs=0x3428, Da=0, rd_out=1.
REQ-026 SHALL cover: ADDS X3,X1,X2 with ex_rd=1, ex_regwrite=1, ex_result=7 -> Da=7 (EX beats MEM and regfile).
REQ-027 SHALL cover: LDUR X4 in EX (ex_memtoreg=1, ex_rd=4), then SUBS X5,X4,X6 in ID -> stall=1 for one cycle, BUBBLE emitted, then 0x2432.
REQ-028 SHALL cover: load-use hazard coincident with flush=1 -> stall=0, BUBBLE emitted.
REQ-029 SHALL cover: wb_en=1, wb_addr=9, wb_data=0xAB while ID reads X9 -> Da=0xAB in the same cycle; a write to X31 reads back 0.
REQ-030 SHALL cover: CBZ X7 with X7=0 -> controlsigs=0x0000, Db=0; an undefined opcode -> 0x0080.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared pipeline constants for the decode stage: control-word
//                bit positions, opcode fields, control-word values per
//                instruction class and the instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int CTRL_W = 14;
  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int RA_W   = 5;

  // Control-word bit positions (MSB first)
  localparam int BIT_REG2LOC  = 13;
  localparam int BIT_ALUSRC   = 12;
  localparam int BIT_MEMTOREG = 11;
  localparam int BIT_REGWRITE = 10;
  localparam int BIT_MEMWRITE = 9;
  localparam int BIT_BRTAKEN  = 8;
  localparam int BIT_UNCONDBR = 7;
  localparam int BIT_ALUOP2   = 6;
  localparam int BIT_ALUOP1   = 5;
  localparam int BIT_ALUOP0   = 4;
  localparam int BIT_BIGIMM   = 3;
  localparam int BIT_SHIFT    = 2;
  localparam int BIT_SETFLAG  = 1;
  localparam int BIT_ISLT     = 0;

  // Opcode fields, compared against the top bits of the instruction
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [4:0]  COND_LT  = 5'b01011;

  // Hard-wired zero register
  localparam logic [RA_W-1:0] REG_ZERO = 5'd31;

  // Control words per instruction class
  localparam logic [CTRL_W-1:0] CTRL_ADDI = 14'h3428;
  localparam logic [CTRL_W-1:0] CTRL_ADDS = 14'h2422;
  localparam logic [CTRL_W-1:0] CTRL_SUBS = 14'h2432;
  localparam logic [CTRL_W-1:0] CTRL_LDUR = 14'h3C20;
  localparam logic [CTRL_W-1:0] CTRL_STUR = 14'h1220;
  localparam logic [CTRL_W-1:0] CTRL_LSR  = 14'h2404;
  localparam logic [CTRL_W-1:0] CTRL_B    = 14'h0180;
  localparam logic [CTRL_W-1:0] CTRL_BLT  = 14'h0001;
  localparam logic [CTRL_W-1:0] CTRL_CBZ  = 14'h0000;
  localparam logic [CTRL_W-1:0] BUBBLE    = 14'h0080;

  // Decoder result: control word plus which source registers are read
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              ra_used;
    logic              rb_used;
  } dec_t;

  // Map an instruction to its control word; unknown encodings become BUBBLE
  function automatic dec_t decode(input logic [ILEN-1:0] ins);
    dec_t d;
    d.ctrl    = BUBBLE;
    d.ra_used = 1'b0;
    d.rb_used = 1'b0;
    if (ins[31:22] == OP_ADDI) begin
      d.ctrl = CTRL_ADDI; d.ra_used = 1'b1;
    end else if (ins[31:21] == OP_ADDS) begin
      d.ctrl = CTRL_ADDS; d.ra_used = 1'b1; d.rb_used = 1'b1;
    end else if (ins[31:21] == OP_SUBS) begin
      d.ctrl = CTRL_SUBS; d.ra_used = 1'b1; d.rb_used = 1'b1;
    end else if (ins[31:21] == OP_LDUR) begin
      d.ctrl = CTRL_LDUR; d.ra_used = 1'b1;
    end else if (ins[31:21] == OP_STUR) begin
      d.ctrl = CTRL_STUR; d.ra_used = 1'b1; d.rb_used = 1'b1;
    end else if (ins[31:21] == OP_LSR) begin
      d.ctrl = CTRL_LSR; d.ra_used = 1'b1;
    end else if (ins[31:26] == OP_B) begin
      d.ctrl = CTRL_B;
    end else if (ins[31:24] == OP_BCOND && ins[4:0] == COND_LT) begin
      d.ctrl = CTRL_BLT;
    end else if (ins[31:24] == OP_CBZ) begin
      d.ctrl = CTRL_CBZ; d.rb_used = 1'b1;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_32x64.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_32x64
//  Description : 32 x 64-bit register file, two asynchronous read ports and
//                one synchronous write port. Entry 31 is never written, so it
//                always holds zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_32x64 import cpu_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd
);

  localparam int DEPTH = 32;

  logic [XLEN-1:0] regs_q [DEPTH];
  logic [XLEN-1:0] regs_d [DEPTH];

  // Next contents: the write port updates one entry, writes to X31 dropped
  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (we && wa != REG_ZERO) regs_d[wa] = wd;
  end

  // Storage array; reset wins over a same-edge write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction decode stage: control decode, register read with
//                EX/MEM/WB bypassing, load-use stall detection and the ID/EX
//                pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage import cpu_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic [ILEN-1:0]   instr_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_regwrite,
  input  logic [XLEN-1:0]   mem_result,
  output logic [XLEN-1:0]   Da,
  output logic [XLEN-1:0]   Db,
  output logic [ILEN-1:0]   instr,
  output logic [CTRL_W-1:0] controlsigs,
  output logic [RA_W-1:0]   rd_out,
  output logic              stall
);

  dec_t            dec;
  logic [RA_W-1:0] ra;
  logic [RA_W-1:0] rb;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;

  logic [XLEN-1:0]   da_q,   da_d;
  logic [XLEN-1:0]   db_q,   db_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [RA_W-1:0]   rd_q,   rd_d;

  // Priority bypass: zero register, then EX, MEM, WB, finally the array
  function automatic logic [XLEN-1:0] bypass(
    input logic [RA_W-1:0] r,
    input logic [XLEN-1:0] rf_val,
    input logic            exw, input logic [RA_W-1:0] exr, input logic [XLEN-1:0] exv,
    input logic            mew, input logic [RA_W-1:0] mer, input logic [XLEN-1:0] mev,
    input logic            wbw, input logic [RA_W-1:0] wbr, input logic [XLEN-1:0] wbv
  );
    if (r == REG_ZERO)                          return '0;
    else if (exw && exr == r && exr != REG_ZERO) return exv;
    else if (mew && mer == r && mer != REG_ZERO) return mev;
    else if (wbw && wbr == r && wbr != REG_ZERO) return wbv;
    else                                         return rf_val;
  endfunction

  regfile_32x64 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra),
    .ra_data (rf_a),
    .rb_addr (rb),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Decode and source-register selection (Reg2Loc picks Rm vs Rt)
  always_comb begin
    dec = decode(instr_in);
    ra  = instr_in[9:5];
    rb  = dec.ctrl[BIT_REG2LOC] ? instr_in[20:16] : instr_in[4:0];
  end

  // Operand values after bypassing
  always_comb begin
    op_a = bypass(ra, rf_a, ex_regwrite, ex_rd, ex_result,
                  mem_regwrite, mem_rd, mem_result, wb_en, wb_addr, wb_data);
    op_b = bypass(rb, rf_b, ex_regwrite, ex_rd, ex_result,
                  mem_regwrite, mem_rd, mem_result, wb_en, wb_addr, wb_data);
  end

  // Load-use hazard: the load in EX targets a source this instruction reads
  always_comb begin
    hazard = ex_memtoreg && ex_regwrite && (ex_rd != REG_ZERO) &&
             ((dec.ra_used && ex_rd == ra) || (dec.rb_used && ex_rd == rb));
    stall  = hazard && !flush && !reset;
  end

  // ID/EX next values: bubble on flush or stall, otherwise the decoded instr
  always_comb begin
    ctrl_d  = BUBBLE;
    instr_d = '0;
    rd_d    = REG_ZERO;
    da_d    = '0;
    db_d    = '0;
    if (!flush && !hazard) begin
      ctrl_d  = dec.ctrl;
      instr_d = instr_in;
      rd_d    = instr_in[4:0];
      da_d    = op_a;
      db_d    = op_b;
    end
  end

  // ID/EX pipeline register, reset to a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= BUBBLE;
      instr_q <= '0;
      rd_q    <= REG_ZERO;
      da_q    <= '0;
      db_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
      da_q    <= da_d;
      db_q    <= db_d;
    end
  end

  assign controlsigs = ctrl_q;
  assign instr       = instr_q;
  assign rd_out      = rd_q;
  assign Da          = da_q;
  assign Db          = db_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Scoreboard bench for id_stage; the driver pushes hand-computed
//                expectations, the monitor pops one per clock and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic [63:0] ex_result;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic [63:0] mem_result;
  logic [63:0] Da, Db;
  logic [31:0] instr;
  logic [13:0] controlsigs;
  logic [4:0]  rd_out;
  logic        stall;

  typedef struct {
    string       nm;
    logic [13:0] cs;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [63:0] da;
    logic [63:0] db;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_result(mem_result), .Da(Da), .Db(Db), .instr(instr),
    .controlsigs(controlsigs), .rd_out(rd_out), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_rd = 31; ex_regwrite = 0; ex_memtoreg = 0; ex_result = 0;
    mem_rd = 31; mem_regwrite = 0; mem_result = 0;
  endtask

  task automatic push(input string nm, input logic [13:0] cs, input logic [31:0] ins,
                      input logic [4:0] rd, input logic [63:0] da, input logic [63:0] db,
                      input logic st);
    exp_t e;
    e.nm = nm; e.cs = cs; e.ins = ins; e.rd = rd; e.da = da; e.db = db; e.st = st;
    sb.push_back(e);
  endtask

  task automatic push_bubble(input string nm, input logic st);
    push(nm, 14'h0080, 32'h0, 5'd31, 64'h0, 64'h0, st);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.nm, "stall", {63'h0, stall}, {63'h0, e.st});
        chk(e.nm, "controlsigs", {50'h0, controlsigs}, {50'h0, e.cs});
        chk(e.nm, "instr", {32'h0, instr}, {32'h0, e.ins});
        chk(e.nm, "rd_out", {59'h0, rd_out}, {59'h0, e.rd});
        chk(e.nm, "Da", Da, e.da);
        chk(e.nm, "Db", Db, e.db);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Driver: inputs change on the falling edge
  initial begin
    reset = 1; instr_in = 32'h910017E1; idle();

    @(negedge clk); push_bubble("reset0", 1'b0);
    @(negedge clk); ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 1;
    push_bubble("reset_hazard", 1'b0);

    // ADDI X1,X31,#5
    @(negedge clk); reset = 0; idle(); instr_in = 32'h910017E1;
    push("addi", 14'h3428, 32'h910017E1, 5'd1, 64'h0, 64'h0, 1'b0);

    // undefined opcode while preloading X6
    @(negedge clk); idle(); instr_in = 32'hFFFFFFFF;
    wb_en = 1; wb_addr = 6; wb_data = 64'h66;
    push("undef", 14'h0080, 32'hFFFFFFFF, 5'd31, 64'h0, 64'h0, 1'b0);

    // ADDS X3,X1,X2: EX beats MEM on X1
    @(negedge clk); idle(); instr_in = 32'hAB020023;
    ex_rd = 1; ex_regwrite = 1; ex_result = 64'h7;
    mem_rd = 1; mem_regwrite = 1; mem_result = 64'h55;
    push("adds_exfwd", 14'h2422, 32'hAB020023, 5'd3, 64'h7, 64'h0, 1'b0);

    // MEM beats WB on X2 (WB also writes X2)
    @(negedge clk); idle(); instr_in = 32'hAB020023;
    mem_rd = 2; mem_regwrite = 1; mem_result = 64'h22;
    wb_en = 1; wb_addr = 2; wb_data = 64'h33;
    push("adds_memfwd", 14'h2422, 32'hAB020023, 5'd3, 64'h0, 64'h22, 1'b0);

    @(negedge clk); idle();
    push("adds_rf", 14'h2422, 32'hAB020023, 5'd3, 64'h0, 64'h33, 1'b0);

    @(negedge clk); idle(); instr_in = 32'hF8000026;
    push("stur", 14'h1220, 32'hF8000026, 5'd6, 64'h0, 64'h66, 1'b0);
    @(negedge clk); idle(); instr_in = 32'hF84000C2;
    push("ldur", 14'h3C20, 32'hF84000C2, 5'd2, 64'h66, 64'h0, 1'b0);
    @(negedge clk); idle(); instr_in = 32'hD34000C1;
    push("lsr", 14'h2404, 32'hD34000C1, 5'd1, 64'h66, 64'h0, 1'b0);
    @(negedge clk); idle(); instr_in = 32'h14000010;
    push("b", 14'h0180, 32'h14000010, 5'd16, 64'h0, 64'h0, 1'b0);
    @(negedge clk); idle(); instr_in = 32'h5400000B;
    push("blt", 14'h0001, 32'h5400000B, 5'd11, 64'h0, 64'h0, 1'b0);
    @(negedge clk); idle(); instr_in = 32'h54000001;
    push("bcond_other", 14'h0080, 32'h54000001, 5'd1, 64'h0, 64'h0, 1'b0);

    // Load-use: LDUR X4 in EX, SUBS X5,X4,X6 in ID
    @(negedge clk); idle(); instr_in = 32'hEB060085;
    ex_rd = 4; ex_regwrite = 1; ex_memtoreg = 1;
    push_bubble("loaduse_stall", 1'b1);
    @(negedge clk); idle();
    mem_rd = 4; mem_regwrite = 1; mem_result = 64'h1234;
    push("loaduse_resume", 14'h2432, 32'hEB060085, 5'd5, 64'h1234, 64'h66, 1'b0);

    // Load-use coincident with flush
    @(negedge clk); idle(); flush = 1;
    ex_rd = 4; ex_regwrite = 1; ex_memtoreg = 1;
    push_bubble("loaduse_flush", 1'b0);

    // Hazard through Rb only
    @(negedge clk); idle();
    ex_rd = 6; ex_regwrite = 1; ex_memtoreg = 1;
    push_bubble("loaduse_rb", 1'b1);

    // Load targeting X31 never stalls and never forwards
    @(negedge clk); idle(); instr_in = 32'h910017E1;
    ex_rd = 31; ex_regwrite = 1; ex_memtoreg = 1; ex_result = 64'hDEAD;
    push("load_x31", 14'h3428, 32'h910017E1, 5'd1, 64'h0, 64'h0, 1'b0);

    // CBZ X7: Ra unused so a load to it does not stall, but still forwards
    @(negedge clk); idle(); instr_in = 32'hB4000067;
    ex_rd = 3; ex_regwrite = 1; ex_memtoreg = 1; ex_result = 64'h5;
    push("cbz", 14'h0000, 32'hB4000067, 5'd7, 64'h5, 64'h0, 1'b0);

    // WB bypass on X9, then readback from the array
    @(negedge clk); idle(); instr_in = 32'h9100052A;
    wb_en = 1; wb_addr = 9; wb_data = 64'hAB;
    push("wb_fwd", 14'h3428, 32'h9100052A, 5'd10, 64'hAB, 64'h0, 1'b0);
    @(negedge clk); idle();
    push("wb_rf", 14'h3428, 32'h9100052A, 5'd10, 64'hAB, 64'h0, 1'b0);

    // Write to X31 is ignored
    @(negedge clk); idle(); instr_in = 32'h910003EB;
    wb_en = 1; wb_addr = 31; wb_data = 64'hFF;
    push("wb_x31", 14'h3428, 32'h910003EB, 5'd11, 64'h0, 64'h0, 1'b0);

    // Reset mid-operation with a hazard and a pending write to X12
    @(negedge clk); idle(); reset = 1; instr_in = 32'h9100052A;
    ex_rd = 9; ex_regwrite = 1; ex_memtoreg = 1;
    wb_en = 1; wb_addr = 12; wb_data = 64'h77;
    push_bubble("reset_mid", 1'b0);

    @(negedge clk); reset = 0; idle(); instr_in = 32'h9100018D;
    push("x12_discarded", 14'h3428, 32'h9100018D, 5'd13, 64'h0, 64'h0, 1'b0);
    @(negedge clk); idle(); instr_in = 32'hD34000C1;
    push("x6_cleared", 14'h2404, 32'hD34000C1, 5'd1, 64'h0, 64'h0, 1'b0);

    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
